// File: rtl/clock_state_array_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_state_array_if
// Description : Lane bundle between the per-channel rate counters (master)
//               and the clock_state_array lane engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_state_array_if #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 16
);
    logic                                clk_en;
    logic [CHANNELS-1:0]                 set_clock_low_i;
    logic [CHANNELS-1:0]                 set_clock_high_i;
    logic [CHANNELS-1:0]                 clock_active_i;
    logic [CHANNELS-1:0]                 clear_state_i;
    logic [CHANNELS-1:0]                 half_rate_elapsed_i;
    logic [CHANNELS-1:0]                 pause_en_i;
    logic [CHANNELS-1:0]                 pause_polarity_i;
    logic [CHANNELS*COUNTER_WIDTH-1:0]   pause_limit_i;
    logic [CHANNELS-1:0]                 unpausable_clk_o;
    logic [CHANNELS-1:0]                 pausable_clk_o;
    logic [CHANNELS-1:0]                 pause_active_o;
    logic [CHANNELS*COUNTER_WIDTH-1:0]   pause_duration_o;
    logic [CHANNELS-1:0]                 rise_o;
    logic [CHANNELS-1:0]                 fall_o;
    logic [CHANNELS-1:0]                 locked_o;

    modport master (
        output clk_en, set_clock_low_i, set_clock_high_i, clock_active_i,
               clear_state_i, half_rate_elapsed_i, pause_en_i,
               pause_polarity_i, pause_limit_i,
        input  unpausable_clk_o, pausable_clk_o, pause_active_o,
               pause_duration_o, rise_o, fall_o, locked_o
    );

    modport slave (
        input  clk_en, set_clock_low_i, set_clock_high_i, clock_active_i,
               clear_state_i, half_rate_elapsed_i, pause_en_i,
               pause_polarity_i, pause_limit_i,
        output unpausable_clk_o, pausable_clk_o, pause_active_o,
               pause_duration_o, rise_o, fall_o, locked_o
    );
endinterface
`default_nettype wire

// File: rtl/clock_state_array.sv
`default_nettype none
// ============================================================================
// Module      : clock_state_array
// Description : CHANNELS independent IO clock lanes. Each lane toggles on
//               half-rate ticks, honours forced set/clear, and offers a
//               level-qualified pause with a measured duration.
//               Optional macro CLK_STATE_ARRAY_PAUSE_TIMER_EN adds a timed
//               auto-resume at pause_limit ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_state_array #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          async_rst,
    clock_state_array_if.slave bus
);

    localparam logic [0:0]               c_RUN     = 1'b0;
    localparam logic [0:0]               c_PAUSED  = 1'b1;
    localparam logic [COUNTER_WIDTH-1:0] c_DUR_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_WIDTH-1:0] c_DUR_MAX = {COUNTER_WIDTH{1'b1}};

`ifndef CLK_STATE_ARRAY_PAUSE_TIMER_EN
    // Without the timer the limit bus has no consumer.
    logic w_unused_limit;
    assign w_unused_limit = ^bus.pause_limit_i;
`endif

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g = g + 1) begin : g_lane
            logic [0:0]               r_state;
            logic [0:0]               w_state_next;
            logic [COUNTER_WIDTH-1:0] r_dur;
            logic [COUNTER_WIDTH-1:0] w_dur_next;
            logic [COUNTER_WIDTH-1:0] w_dur_inc;
            logic                     r_unp;
            logic                     r_pcl;
            logic                     r_prev;
            logic                     r_locked;
            logic                     w_level_ok;
            logic                     w_count;
            logic                     w_armed;

            assign w_level_ok = bus.clock_active_i[g] & ~bus.half_rate_elapsed_i[g] &
                                (r_unp == bus.pause_polarity_i[g]);
            assign w_count    = bus.clock_active_i[g] & bus.half_rate_elapsed_i[g];
            assign w_dur_inc  = r_dur + c_DUR_ONE;

`ifdef CLK_STATE_ARRAY_PAUSE_TIMER_EN
            logic                     r_armed;
            logic                     w_timeout;
            logic [COUNTER_WIDTH-1:0] w_limit;

            assign w_limit = bus.pause_limit_i[g*COUNTER_WIDTH +: COUNTER_WIDTH];
            assign w_armed = r_armed;

            // Re-arm only once pause_en is seen low so a held request cannot re-pause after timeout
            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    r_armed <= 1'b0;
                end else if (bus.clk_en) begin
                    if (w_timeout) begin
                        r_armed <= 1'b0;
                    end else if (!bus.pause_en_i[g]) begin
                        r_armed <= 1'b1;
                    end
                end
            end
`else
            assign w_armed = 1'b1;
`endif

            // Pause FSM next state and duration counter: clear, then level transitions, then timer
            always_comb begin
                w_state_next = r_state;
                w_dur_next   = r_dur;
`ifdef CLK_STATE_ARRAY_PAUSE_TIMER_EN
                w_timeout    = 1'b0;
`endif
                if (bus.clear_state_i[g]) begin
                    w_state_next = c_RUN;
                    w_dur_next   = '0;
                end else if (r_state == c_RUN) begin
                    if (bus.pause_en_i[g] && w_level_ok && w_armed) begin
                        w_state_next = c_PAUSED;
                        w_dur_next   = '0;
                    end
                end else if (!bus.pause_en_i[g] && w_level_ok) begin
                    w_state_next = c_RUN;
                end else begin
                    if (w_count && (r_dur != c_DUR_MAX)) begin
                        w_dur_next = w_dur_inc;
                    end
`ifdef CLK_STATE_ARRAY_PAUSE_TIMER_EN
                    // A saturated count wraps w_dur_inc to zero, which a non-zero limit never matches
                    if (w_count && (w_limit != '0) && (w_dur_inc == w_limit)) begin
                        w_state_next = c_RUN;
                        w_timeout    = 1'b1;
                    end
`endif
                end
            end

            // Lane state registers; set_low beats set_high beats toggle/copy on both clocks
            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    r_state  <= c_RUN;
                    r_dur    <= '0;
                    r_unp    <= 1'b0;
                    r_pcl    <= 1'b0;
                    r_prev   <= 1'b0;
                    r_locked <= 1'b0;
                end else if (bus.clk_en) begin
                    r_state  <= w_state_next;
                    r_dur    <= w_dur_next;
                    r_prev   <= r_pcl;
                    r_locked <= bus.clock_active_i[g];

                    if (bus.set_clock_low_i[g]) begin
                        r_unp <= 1'b0;
                    end else if (bus.set_clock_high_i[g]) begin
                        r_unp <= 1'b1;
                    end else if (w_count) begin
                        r_unp <= ~r_unp;
                    end

                    if (bus.set_clock_low_i[g]) begin
                        r_pcl <= 1'b0;
                    end else if (bus.set_clock_high_i[g]) begin
                        r_pcl <= 1'b1;
                    end else if (bus.clock_active_i[g] && (r_state == c_RUN)) begin
                        r_pcl <= r_unp;
                    end
                end
            end

            assign bus.unpausable_clk_o[g] = r_unp;
            assign bus.pausable_clk_o[g]   = r_pcl;
            assign bus.pause_active_o[g]   = (r_state == c_PAUSED);
            assign bus.pause_duration_o[g*COUNTER_WIDTH +: COUNTER_WIDTH] = r_dur;
            assign bus.rise_o[g]           = bus.clk_en &  r_pcl & ~r_prev;
            assign bus.fall_o[g]           = bus.clk_en & ~r_pcl &  r_prev;
            assign bus.locked_o[g]         = r_locked;
        end
    endgenerate

endmodule
`default_nettype wire
